move_overlay_ctrl: RTL and testbench

Sequencer for the move-option overlay. It takes a square selection from the cursor logic and requests the 64-bit legal-move mask from the move generator over a req/ack handshake. The returned mask is held in a shadow register and swapped into the overlay's `move_options` / `valid` / `turn` inputs only on a frame boundary, so the VGA overlay never tears mid-frame.

---
 rtl/chess_pkg.sv | 20 ++
 rtl/move_overlay_ctrl_if.sv | 24 ++
 rtl/move_overlay_ctrl_blink.sv | 38 +++
 rtl/move_overlay_ctrl.sv | 140 ++++++++++++++
 tb/tb_move_overlay_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared types and sizing helpers for the move-option overlay sequencer.
package chess_pkg;

  localparam int unsigned SQUARES = 64;
  localparam int unsigned POS_W   = 6;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StArmed,
    StShow,
    StClearing
  } ovl_state_t;

  // Width of a counter that runs 0 .. cycles-1; never narrower than one bit.
  function automatic int unsigned tmo_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/move_overlay_ctrl_if.sv
// Request/acknowledge link between the overlay sequencer and the move generator.
interface move_overlay_ctrl_if;
  import chess_pkg::*;

  logic               gen_req;
  logic [POS_W-1:0]   gen_pos;
  logic               gen_ack;
  logic [SQUARES-1:0] gen_mask;

  modport master (
    output gen_req,
    output gen_pos,
    input  gen_ack,
    input  gen_mask
  );

  modport slave (
    input  gen_req,
    input  gen_pos,
    output gen_ack,
    output gen_mask
  );

endinterface

// File: rtl/move_overlay_ctrl_blink.sv
// blink_timer: frame counter and on/off phase for the overlay blink.
// Only built when MOVE_OVERLAY_BLINK_EN is defined.
`ifdef MOVE_OVERLAY_BLINK_EN
module blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic restart,
  input  logic run,
  output logic phase
);

  localparam int unsigned CntW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (run && frame_start) begin
      if (cnt_q == CntLast) begin
        cnt_q <= '0;
        phase <= ~phase;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/move_overlay_ctrl.sv
// Move-option overlay sequencer: fetches the legal-move mask and swaps it in on frame boundaries.
// Optional blinking of the displayed overlay is enabled by defining MOVE_OVERLAY_BLINK_EN.
module move_overlay_ctrl
  import chess_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned BLINK_FRAMES   = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_strobe,
  input  logic [POS_W-1:0]    sel_pos,
  input  logic                turn_in,
  input  logic                clear,
  move_overlay_ctrl_if.master gen,
  input  logic                frame_start,
  output logic [SQUARES-1:0]  move_options,
  output logic                valid,
  output logic                turn,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned TmoW = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  ovl_state_t         state_q;
  logic [POS_W-1:0]   pos_q;
  logic               pend_turn_q;
  logic [SQUARES-1:0] shadow_q;
  logic [TmoW-1:0]    tmo_cnt_q;
  logic               req_q;
  logic               busy_q;
  logic               tmo_err_q;
  logic [SQUARES-1:0] mask_q;
  logic               valid_q;
  logic               turn_q;

  logic swap;
  assign swap = (state_q == StArmed) && frame_start && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      pend_turn_q <= 1'b0;
      shadow_q    <= '0;
      tmo_cnt_q   <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      mask_q      <= '0;
      valid_q     <= 1'b0;
      turn_q      <= 1'b0;
    end else begin
      tmo_err_q <= 1'b0;
      case (state_q)
        StIdle, StShow: begin
          if (clear && state_q == StShow) begin
            state_q <= StClearing;
          end else if (sel_strobe && !clear) begin
            // Current display stays up until the new mask swaps in.
            pos_q       <= sel_pos;
            pend_turn_q <= turn_in;
            tmo_cnt_q   <= '0;
            req_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (clear) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StClearing;
          end else if (gen.gen_ack) begin
            shadow_q <= gen.gen_mask;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StArmed;
          end else if (tmo_cnt_q == TmoLast) begin
            tmo_err_q <= 1'b1;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StClearing;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StArmed: begin
          if (clear) begin
            state_q <= StClearing;
          end else if (swap) begin
            mask_q  <= shadow_q;
            valid_q <= (shadow_q != '0);
            turn_q  <= pend_turn_q;
            state_q <= StShow;
          end
        end
        StClearing: begin
          if (frame_start && !clear) begin
            mask_q  <= '0;
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gen.gen_req  = req_q;
  assign gen.gen_pos  = pos_q;
  assign move_options = mask_q;
  assign turn         = turn_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_err_q;

`ifdef MOVE_OVERLAY_BLINK_EN
  logic blink_phase;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .restart     (swap),
    .run         (state_q == StShow),
    .phase       (blink_phase)
  );

  assign valid = valid_q & blink_phase;
`else
  logic unused_blink;
  assign unused_blink = (BLINK_FRAMES == 0);
  assign valid        = valid_q;
`endif

endmodule

// File: tb/tb_move_overlay_ctrl.sv
// Self-checking bench for move_overlay_ctrl: directed corner cases plus randomized requests.
module tb_move_overlay_ctrl;
  import chess_pkg::*;

  localparam int unsigned T  = 12;
  localparam int unsigned BF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel_strobe;
  logic [5:0]   sel_pos;
  logic         turn_in;
  logic         clear;
  logic         frame_start;
  logic [63:0]  move_options;
  logic         valid;
  logic         turn;
  logic         busy;
  logic         timeout_err;

  move_overlay_ctrl_if gif ();

  move_overlay_ctrl #(
    .TIMEOUT_CYCLES (T),
    .BLINK_FRAMES   (BF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_strobe   (sel_strobe),
    .sel_pos      (sel_pos),
    .turn_in      (turn_in),
    .clear        (clear),
    .gen          (gif),
    .frame_start  (frame_start),
    .move_options (move_options),
    .valid        (valid),
    .turn         (turn),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference view of what the overlay should be showing.
  logic [63:0] m_mask;
  logic        m_nz;
  logic        m_turn;
  int          m_frames;    // frames seen in SHOW since the last swap
  logic [63:0] pend_mask;
  logic        pend_turn;
  bit          last_tmo;

  function automatic logic blink_on(input int f);
`ifdef MOVE_OVERLAY_BLINK_EN
    return ((f / int'(BF)) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_display(input string tag);
    chk({tag, "_mask"}, move_options, m_mask);
    chk({tag, "_valid"}, valid, m_nz & blink_on(m_frames));
    chk({tag, "_turn"}, turn, m_turn);
  endtask

  // Select a square; the generator acks in request cycle ack_at (beyond T means never).
  task automatic request(input logic [5:0] pos, input logic t, input logic [63:0] mask,
                         input int ack_at, input bit ack_frame);
    int n;
    bit tmo;
    sel_pos    = pos;
    turn_in    = t;
    sel_strobe = 1'b1;
    step();
    sel_strobe = 1'b0;
    n = 0;
    while (gif.gen_req === 1'b1 && n < int'(T) + 4) begin
      n++;
      chk("gen_pos", {58'd0, gif.gen_pos}, {58'd0, pos});
      chk("busy", busy, 1);
      check_display("hold");
      sel_strobe = ($urandom_range(0, 3) == 0);
      sel_pos    = 6'($urandom);
      if (n == ack_at) begin
        gif.gen_ack  = 1'b1;
        gif.gen_mask = mask;
        frame_start  = ack_frame;
      end else begin
        frame_start = ($urandom_range(0, 4) == 0);
      end
      step();
      sel_strobe   = 1'b0;
      frame_start  = 1'b0;
      gif.gen_ack  = 1'b0;
      gif.gen_mask = {$urandom, $urandom};
    end
    tmo = (ack_at < 1) || (ack_at > int'(T));
    chk("req_cycles", n, tmo ? T : ack_at);
    chk("timeout_err", timeout_err, tmo);
    chk("busy_drop", busy, 0);
    step();
    chk("timeout_pulse", timeout_err, 0);
    check_display("armed");
    last_tmo  = tmo;
    pend_mask = mask;
    pend_turn = t;
  endtask

  task automatic late_acks(input int k);
    for (int i = 0; i < k; i++) begin
      gif.gen_ack  = $urandom_range(0, 1) == 1;
      gif.gen_mask = {$urandom, $urandom};
      step();
      gif.gen_ack = 1'b0;
      check_display("late");
    end
  endtask

  task automatic swap_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (last_tmo) begin
      m_mask = '0;
      m_nz   = 1'b0;
    end else begin
      m_mask   = pend_mask;
      m_nz     = (pend_mask != '0);
      m_turn   = pend_turn;
      m_frames = 0;
    end
    check_display("swap");
  endtask

  initial begin
    logic [63:0] rmask;
    int          rack;

    rst          = 1'b1;
    sel_strobe   = 1'b0;
    sel_pos      = '0;
    turn_in      = 1'b0;
    clear        = 1'b0;
    frame_start  = 1'b0;
    gif.gen_ack  = 1'b0;
    gif.gen_mask = '0;
    m_mask       = '0;
    m_nz         = 1'b0;
    m_turn       = 1'b0;
    m_frames     = 0;
    last_tmo     = 1'b0;
    pend_mask    = '0;
    pend_turn    = 1'b0;

    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_gen_req", gif.gen_req, 0);
    chk("rst_gen_pos", {58'd0, gif.gen_pos}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    check_display("rst");

    // Basic fetch: ack in the sixth request cycle.
    request(6'd12, 1'b0, 64'h0000_0000_1010_0000, 6, 1'b0);
    late_acks(2);
    swap_frame();
    chk("basic_mask", move_options, 64'h0000_0000_1010_0000);

    // Timeout clears the display only at the next frame.
    request(6'd20, 1'b1, 64'hFF, int'(T) + 1, 1'b0);
    late_acks(3);
    swap_frame();

    // Empty mask: overlay disabled but the controller sits in SHOW.
    request(6'd5, 1'b1, 64'h0, 3, 1'b0);
    swap_frame();
    chk("state_show", dut.state_q, StShow);

    // Ack coinciding with frame_start defers the swap.
    request(6'd33, 1'b1, 64'h8000_0000_0000_0001, 2, 1'b1);
    late_acks(1);
    swap_frame();

    // Frames while showing: blink pattern or static.
    for (int i = 1; i <= 4; i++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      m_frames++;
      check_display("blink");
    end

    // clear beats sel_strobe in SHOW.
    sel_pos    = 6'd7;
    sel_strobe = 1'b1;
    clear      = 1'b1;
    step();
    sel_strobe = 1'b0;
    clear      = 1'b0;
    chk("clr_sel_req", gif.gen_req, 0);
    chk("clr_sel_busy", busy, 0);
    check_display("clr_hold");
    step();
    chk("clr_sel_req2", gif.gen_req, 0);
    last_tmo = 1'b1;
    swap_frame();

    // clear in IDLE and frames in IDLE change nothing.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_display("idle_clr");
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_display("idle_frame");

    // clear mid-request.
    request(6'd9, 1'b0, 64'h0000_0400_0000_0000, 4, 1'b0);
    swap_frame();
    sel_pos    = 6'd40;
    sel_strobe = 1'b1;
    step();
    sel_strobe = 1'b0;
    step();
    chk("mid_req_up", gif.gen_req, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("mid_clr_req", gif.gen_req, 0);
    chk("mid_clr_busy", busy, 0);
    check_display("mid_clr_hold");
    last_tmo = 1'b1;
    swap_frame();

    // Reset mid-request drops the request at once and discards the shadow.
    request(6'd50, 1'b1, 64'h0000_0000_0000_F000, 2, 1'b0);
    swap_frame();
    sel_pos    = 6'd51;
    sel_strobe = 1'b1;
    step();
    sel_strobe = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("arst_req", gif.gen_req, 0);
    chk("arst_mask", move_options, 0);
    m_mask   = '0;
    m_nz     = 1'b0;
    m_turn   = 1'b0;
    m_frames = 0;
    step();
    rst = 1'b0;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_display("post_rst");

    // Randomized requests.
    for (int it = 0; it < 24; it++) begin
      rmask = ($urandom_range(0, 5) == 0) ? 64'h0 : {$urandom, $urandom};
      rack  = ($urandom_range(0, 5) == 0) ? int'(T) + 1 : int'($urandom_range(1, T));
      request(6'($urandom), 1'($urandom), rmask, rack, 1'($urandom_range(0, 1)));
      late_acks(int'($urandom_range(0, 3)));
      swap_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
